srd_rst_req_gen: RTL

//  Per-port reset-request generator, upstream of the HSSI reset controller (i_clk = CSR clock).

---
 rtl/srd_rst_req_gen.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/srd_rst_req_gen.sv
// srd_rst_req_gen
//   Per-port reset-request generator sitting upstream of the HSSI reset
//   controller. CSR soft-reset pulses and TX PLL lock status become the
//   active-low sys/tx/rx reset requests. Each request is held for at least
//   MIN_PULSE locked cycles, then the selected acks must go low and later
//   high again. Each ack wait gives up after ACK_TIMEOUT cycles and sets a
//   sticky flag. Soft requests that arrive mid-sequence are queued.
//
//   Optional feature: define SRD_RX_AUTO_RST_EN to raise an RX request
//   automatically when i_rx_pcs_ready stays low for DEBOUNCE cycles in RUN.
//
//   Legal configuration: MIN_PULSE >= 2 and ACK_TIMEOUT >= MIN_PULSE.
module srd_rst_req_gen #(
  parameter int MIN_PULSE   = 16,
  parameter int ACK_TIMEOUT = 4096,
  parameter int DEBOUNCE    = 256
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_locked,
  input  logic       i_soft_rst,
  input  logic       i_soft_tx_rst,
  input  logic       i_soft_rx_rst,
  input  logic       i_rst_ack_n,
  input  logic       i_tx_rst_ack_n,
  input  logic       i_rx_rst_ack_n,
  input  logic       i_rx_pcs_ready,
  input  logic       i_clr_timeout,
  output logic       o_sys_rst_n,
  output logic       o_sys_tx_rst_n,
  output logic       o_sys_rx_rst_n,
  output logic       o_busy,
  output logic       o_ack_timeout,
  output logic [2:0] o_state
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;

  // Mask bit order is {SYS, TX, RX}.
  localparam logic [2:0] MASK_ALL  = 3'b111;
  localparam logic [2:0] MASK_NONE = 3'b000;

  localparam logic [CNT_W-1:0] CNT_PULSE_END = CNT_W'(MIN_PULSE - 1);
  localparam logic [CNT_W-1:0] CNT_WAIT_END  = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_ACK  = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       mask_q, mask_d;
  logic [2:0]       pend_q, pend_d;
  logic [2:0]       rst_low_q, rst_low_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]       state_rb_q;
  logic             timeout_q, timeout_set;

  logic [2:0] acks_n;
  logic       acks_low, acks_high;
  logic       pll_loss;
  logic       auto_rx_req;
  logic [2:0] soft_req;

  assign acks_n    = {i_rst_ack_n, i_tx_rst_ack_n, i_rx_rst_ack_n};
  assign acks_low  = ((acks_n & mask_q) == MASK_NONE);
  assign acks_high = ((acks_n & mask_q) == mask_q);

  // Lock can only be low in WAIT_ACK..RUN on the cycle it falls: every path
  // into those states requires lock, and any drop leaves them at once.
  // So the level is enough to detect the 1->0 transition.
  assign pll_loss = ~i_pll_locked;

  // A full soft reset implies TX and RX as well.
  assign soft_req = {i_soft_rst,
                     i_soft_rst | i_soft_tx_rst,
                     i_soft_rst | i_soft_rx_rst | auto_rx_req};

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef SRD_RX_AUTO_RST_EN
  localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DEB_W-1:0] DEB_END = DEB_W'(DEBOUNCE - 1);

  logic [DEB_W-1:0] deb_q;

  // Count consecutive low samples of PCS ready while the port is running.
  always_ff @(posedge i_clk) begin
    if (i_rst || state_q != ST_RUN || i_rx_pcs_ready) begin
      deb_q <= '0;
    end else if (deb_q != DEB_END) begin
      deb_q <= deb_q + 1'b1;
    end
  end

  // The DEBOUNCE-th consecutive low sample raises the request.
  assign auto_rx_req = (state_q == ST_RUN) && !i_rx_pcs_ready && (deb_q == DEB_END);
`else
  logic unused_rx_pcs_ready;
  assign unused_rx_pcs_ready = i_rx_pcs_ready & (DEBOUNCE > 0);
  assign auto_rx_req         = 1'b0;
`endif

  // Sequencer next state, mask, counter and pending-request queue.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    timeout_set = 1'b0;

    unique case (state_q)
      ST_ASSERT: begin
        pend_d = pend_q | soft_req;
        if (pll_loss) begin
          mask_d = MASK_ALL;
          cnt_d  = '0;
        end else if (cnt_q == CNT_PULSE_END) begin
          state_d = ST_WAIT_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_WAIT_ACK: begin
        pend_d = pend_q | soft_req;
        if (pll_loss) begin
          state_d = ST_ASSERT;
          mask_d  = MASK_ALL;
          cnt_d   = '0;
        end else if (acks_low) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_WAIT_END) begin
          timeout_set = 1'b1;
          state_d     = ST_RELEASE;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RELEASE: begin
        pend_d = pend_q | soft_req;
        cnt_d  = '0;
        if (pll_loss) begin
          state_d = ST_ASSERT;
          mask_d  = MASK_ALL;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        pend_d = pend_q | soft_req;
        if (pll_loss) begin
          state_d = ST_ASSERT;
          mask_d  = MASK_ALL;
          cnt_d   = '0;
        end else if (acks_high) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_WAIT_END) begin
          timeout_set = 1'b1;
          state_d     = ST_RUN;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RUN: begin
        cnt_d = '0;
        if (pll_loss || i_soft_rst) begin
          // A full reset covers anything still queued.
          state_d = ST_ASSERT;
          mask_d  = MASK_ALL;
          pend_d  = MASK_NONE;
        end else if (pend_q != MASK_NONE) begin
          // Same-cycle TX/RX pulses are queued behind the pending request.
          state_d = ST_ASSERT;
          mask_d  = pend_q;
          pend_d  = soft_req;
        end else if (soft_req != MASK_NONE) begin
          state_d = ST_ASSERT;
          mask_d  = soft_req;
        end
      end

      default: begin
        state_d = ST_ASSERT;
        mask_d  = MASK_ALL;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs lag the state by one edge, except that a lock loss outside RUN
  // pulls all three requests low on the very next edge.
  always_comb begin
    rst_low_d = MASK_NONE;
    if (state_q == ST_ASSERT || state_q == ST_WAIT_ACK) begin
      rst_low_d = mask_q;
    end
    if (pll_loss && state_q != ST_RUN) begin
      rst_low_d = MASK_ALL;
    end
  end

  // State, counters and registered request outputs.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (i_rst) begin
      state_q    <= ST_ASSERT;
      state_rb_q <= ST_ASSERT;
      mask_q     <= MASK_ALL;
      pend_q     <= MASK_NONE;
      cnt_q      <= '0;
      rst_low_q  <= MASK_ALL;
    end else begin
      state_q    <= state_d;
      state_rb_q <= state_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      rst_low_q  <= rst_low_d;
    end
  end

  // Sticky ack-timeout flag; a new timeout beats a clear in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timeout_q <= 1'b0;
    end else if (timeout_set) begin
      timeout_q <= 1'b1;
    end else if (i_clr_timeout) begin
      timeout_q <= 1'b0;
    end
  end

  assign o_sys_rst_n    = ~rst_low_q[2];
  assign o_sys_tx_rst_n = ~rst_low_q[1];
  assign o_sys_rx_rst_n = ~rst_low_q[0];
  assign o_busy         = (state_q != ST_RUN);
  assign o_ack_timeout  = timeout_q;
  assign o_state        = state_rb_q;

endmodule
